// File: rtl/reaction_game_ctrl.sv
// Reaction-game round controller: blink, random dark wait, timed reaction window, foul and score tracking.
// Press to RESULT takes 1 clk and best_ms follows 1 clk later; no backpressure, every input is sampled each clk.
module reaction_game_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_W      = 5,
  parameter int TIME_W       = 20,
  parameter int BLINK_MS     = 5000,
  parameter int MIN_WAIT_MS  = 2000,
  parameter int MAX_REACT_MS = 9999
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ms_tick,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         player_n,
  input  logic [13:0]                    rand_wait,
  output logic [2:0]                     state_code,
  output logic [TIME_W-1:0]              reaction_ms,
  output logic [2:0]                     winner_id,
  output logic                           false_start,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [TIME_W-1:0]              best_ms,
  output logic                           match_over
);

  typedef enum logic [2:0] {
    ST_BLINK      = 3'd0,
    ST_WAIT       = 3'd1,
    ST_REACT      = 3'd2,
    ST_RESULT     = 3'd3,
    ST_FOUL       = 3'd4,
    ST_TIMEOUT    = 3'd5,
    ST_MATCH_OVER = 3'd6
  } state_t;

  state_t                         state_q, state_d;
  logic [TIME_W-1:0]              cnt_q, cnt_d;
  logic [15:0]                    wait_tgt_q, wait_tgt_d;
  logic [TIME_W-1:0]              react_q, react_d;
  logic [2:0]                     win_q, win_d;
  logic                           fs_q, fs_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
  logic [TIME_W-1:0]              best_q, best_d;
  logic                           mo_q, mo_d;
  logic                           first_q, first_d;

  logic [NUM_PLAYERS-1:0]         pressed;
  logic                           any_press;
  logic [2:0]                     low_id;
  logic                           win_full;
  logic [TIME_W-1:0]              cnt_inc;
  logic [TIME_W-1:0]              react_inc;

  function automatic logic [2:0] lowest_pressed(input logic [NUM_PLAYERS-1:0] p);
    lowest_pressed = 3'd0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (p[i]) lowest_pressed = 3'(i);
    end
  endfunction

  assign pressed   = ~player_n;
  assign any_press = |pressed;
  assign low_id    = lowest_pressed(pressed);
  assign cnt_inc   = cnt_q + 1'b1;
  assign react_inc = react_q + 1'b1;

  always_comb begin
    win_full = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (3'(i) == win_q) win_full = &scores_q[i*SCORE_W +: SCORE_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_tgt_d = wait_tgt_q;
    react_d    = react_q;
    win_d      = win_q;
    fs_d       = 1'b0;
    scores_d   = scores_q;
    best_d     = best_q;
    first_d    = 1'b0;

    case (state_q)
      ST_BLINK: begin
        if (ms_tick) begin
          if (cnt_inc == TIME_W'(BLINK_MS)) begin
            state_d    = ST_WAIT;
            cnt_d      = '0;
            wait_tgt_d = 16'(MIN_WAIT_MS) + 16'(rand_wait);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_WAIT: begin
        // A press on the same cycle as the final tick still counts as a foul.
        if (any_press) begin
          state_d = ST_FOUL;
          win_d   = low_id;
          fs_d    = 1'b1;
        end else if (ms_tick) begin
          if (cnt_inc == TIME_W'(wait_tgt_q)) begin
            state_d = ST_REACT;
            cnt_d   = '0;
            react_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_REACT: begin
        if (any_press) begin
          state_d = ST_RESULT;
          win_d   = low_id;
          first_d = 1'b1;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (3'(i) == low_id)
              scores_d[i*SCORE_W +: SCORE_W] = {scores_q[i*SCORE_W +: SCORE_W-1], 1'b1};
          end
        end else if (ms_tick) begin
          react_d = react_inc;
          if (react_inc == TIME_W'(MAX_REACT_MS)) state_d = ST_TIMEOUT;
        end
      end
      ST_RESULT: begin
        if (first_q && (react_q < best_q)) best_d = react_q;
        if (win_full) state_d = ST_MATCH_OVER;
      end
      ST_FOUL, ST_TIMEOUT, ST_MATCH_OVER: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_BLINK;
        cnt_d   = '0;
      end
    endcase

    if (start) begin
      state_d = ST_BLINK;
      cnt_d   = '0;
      if (state_q == ST_MATCH_OVER) scores_d = '0;
    end
  end

  assign mo_d = (state_d == ST_MATCH_OVER);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_BLINK;
      cnt_q      <= '0;
      wait_tgt_q <= '0;
      react_q    <= '0;
      win_q      <= '0;
      fs_q       <= 1'b0;
      scores_q   <= '0;
      best_q     <= '1;
      mo_q       <= 1'b0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_tgt_q <= wait_tgt_d;
      react_q    <= react_d;
      win_q      <= win_d;
      fs_q       <= fs_d;
      scores_q   <= scores_d;
      best_q     <= best_d;
      mo_q       <= mo_d;
      first_q    <= first_d;
    end
  end

  assign state_code  = state_q;
  assign reaction_ms = react_q;
  assign winner_id   = win_q;
  assign false_start = fs_q;
  assign scores      = scores_q;
  assign best_ms     = best_q;
  assign match_over  = mo_q;

endmodule

// File: doc/reaction_game_ctrl.md
# reaction_game_ctrl

Parametrised round controller for the multi-player reaction-time game. It sequences blink → random wait → timed reaction window, and picks the first player to press. It penalises presses made before the window opens, keeps per-player thermometer scores, tracks the best reaction time, and declares a match winner. It sits between the ms clock divider, the random-wait generator and the debounced player keys on one side, and the display mux, BCD converters and LED score bars on the other.

## Interface
- `NUM_PLAYERS`, 2 — number of players, legal range 2..8.
- `SCORE_W`, 5 — score bar length in LEDs; a full bar wins the match.
- `TIME_W`, 20 — width of the ms time values.
- `BLINK_MS`, 5000 — length of the blink phase in ms.
- `MIN_WAIT_MS`, 2000 — fixed part of the dark wait in ms.
- `MAX_REACT_MS`, 9999 — reaction window limit in ms.
- `clk  in  1` — 50 MHz system clock.
- `reset_n  in  1` — synchronous, active-low reset.
- `ms_tick  in  1` — one-`clk` pulse per millisecond, from the clock divider.
- `start  in  1` — one-`clk` start/resume pulse, already edge-detected.
- `player_n  in  NUM_PLAYERS` — active-low player buttons, already synchronised and debounced; bit i is player i.
- `rand_wait  in  14` — random extra wait in ms.
- `state_code  out  3` — current state, for the display mux select.
- `reaction_ms  out  TIME_W` — live or frozen reaction time.
- `winner_id  out  3` — winning player, or fouling player in FOUL.
- `false_start  out  1` — one-`clk` pulse on entry to FOUL.
- `scores  out  NUM_PLAYERS*SCORE_W` — thermometer bars; player i occupies bits [i*SCORE_W +: SCORE_W].
- `best_ms  out  TIME_W` — fastest valid reaction since reset.
- `match_over  out  1` — high while in MATCH_OVER.

## Operation
- States and `state_code` values: BLINK=0, WAIT=1, REACT=2, RESULT=3, FOUL=4, TIMEOUT=5, MATCH_OVER=6. Code 7 is unused; if reached, go to BLINK.
- Reset values: state BLINK, all counters 0, `reaction_ms` 0, `winner_id` 0, `false_start` 0, `scores` 0, `best_ms` all-ones, `match_over` 0.
- BLINK:
  - The phase counter counts `ms_tick`.
  - On count == `BLINK_MS`, go to WAIT; capture `wait_target = MIN_WAIT_MS + rand_wait` (16-bit, no overflow) and clear the counter.
  - Presses are ignored.
- WAIT:
  - The counter counts `ms_tick`; on count == `wait_target`, go to REACT and clear `reaction_ms`.
  - Any press before that goes to FOUL, `winner_id` = lowest pressed index, and `false_start` pulses. Scores are unchanged.
  - If a press and the target tick fall in the same cycle, the press wins: FOUL.
- REACT:
  - `reaction_ms` increments on each `ms_tick`.
  - On a press, go to RESULT: `winner_id` = lowest pressed index, and `reaction_ms` freezes at its pre-increment value if `ms_tick` coincides.
  - On the same edge, the winner's bar shifts left with a 1 inserted, saturating at all-ones.
  - If `reaction_ms` reaches `MAX_REACT_MS` with no press, go to TIMEOUT; `reaction_ms` holds `MAX_REACT_MS` and no score changes.
- RESULT:
  - On the first cycle, if `reaction_ms < best_ms` (strict), load `best_ms`.
  - If the winner's bar is full, go to MATCH_OVER on the next edge; otherwise hold.
- RESULT, FOUL and TIMEOUT hold until `start`.
- `start`:
  - In any state other than MATCH_OVER: go to BLINK with counters cleared. Scores and `best_ms` are kept.
  - In MATCH_OVER: additionally clear `scores` and deassert `match_over`.
- `reset_n` low overrides `start` and any press in the same cycle.

## Timing
- All registers update on the rising edge of `clk`. Outputs are registered.
- Round-phase timing is in `ms_tick` units. The BLINK→WAIT transition fires on the edge of the `BLINK_MS`-th tick.
- Press-to-RESULT latency is 1 `clk`. The score update is visible on the same edge as `state_code`=3. `best_ms` updates 1 `clk` later.
- `false_start` is high for exactly 1 `clk`.
- Button levels are sampled every `clk`. A button held across a transition counts in the new state; a key held from WAIT into REACT is a foul, not a win.

## Test plan
- Nominal round:
  - Stimulus: `rand_wait`=500, player 1 presses 250 ticks into REACT.
  - Response: BLINK lasts 5000 ticks and WAIT 2500; RESULT with `winner_id`=1, `reaction_ms`=250, player-1 bar 00001, `best_ms`=250.
- False start:
  - Stimulus: player 0 presses 100 ticks into WAIT.
  - Response: FOUL, `winner_id`=0, one-cycle `false_start`, scores unchanged; `start` returns to BLINK.
- Simultaneous press:
  - Stimulus: players 2 and 1 press in the same REACT cycle, coinciding with `ms_tick` at count 40.
  - Response: `winner_id`=1, `reaction_ms`=40.
- Timeout:
  - Stimulus: no press in REACT.
  - Response: TIMEOUT after 9999 ticks, `reaction_ms`=9999, scores and `best_ms` unchanged.
- Match over:
  - Stimulus: player 0 wins 5 rounds with times 300, 200, 400, 200, 350.
  - Response: bar 11111, MATCH_OVER, `match_over`=1, `best_ms`=200; `start` clears scores and keeps `best_ms`=200.
- Reset and start mid-operation:
  - Stimulus: `reset_n` low in REACT with a press and `start` in the same cycle.
  - Response: all reset values restored.
  - Stimulus: `start` in WAIT.
  - Response: BLINK, scores kept.
